// File: rtl/dvb_s2_ts_null_inserter_if.sv
// dvb_s2_ts_null_inserter_if: TS byte input stream and request-paced output stream
// Ports: in_data/in_valid/in_syn carry source bytes; out_req asks for one byte, which comes back
//   on out_data/out_valid/out_syn/out_null one cycle later. slave = inserter side, master = driver side.
interface dvb_s2_ts_null_inserter_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_syn;
  logic out_req;
  logic [7:0] out_data;
  logic out_valid;
  logic out_syn;
  logic out_null;
  modport slave (
    input in_data, in_valid, in_syn, out_req,
    output out_data, out_valid, out_syn, out_null
  );
  modport master (
    output in_data, in_valid, in_syn, out_req,
    input out_data, out_valid, out_syn, out_null
  );
endinterface

// File: rtl/dvb_s2_ts_null_inserter.sv
// dvb_s2_ts_null_inserter: rebuilds TS packets into a slot buffer and paces them out, filling gaps with null packets
// Ports: sys_clk, rst (sync, active-high); bus (slave) carries the input stream and the paced output;
//   pkt_in_cnt/null_cnt/drop_cnt are wrapping counters of committed, null and dropped packets.
module dvb_s2_ts_null_inserter #(
  parameter int SLOT_BITS = 2,
  parameter int PKT_LEN = 188
) (
  input logic sys_clk,
  input logic rst,
  dvb_s2_ts_null_inserter_if.slave bus,
  output logic [31:0] pkt_in_cnt,
  output logic [31:0] null_cnt,
  output logic [31:0] drop_cnt
);
  localparam int DEPTH = 1 << SLOT_BITS;
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);
  localparam logic [SLOT_BITS+1:0] FULL = (SLOT_BITS + 2)'(DEPTH);
  typedef enum logic [1:0] {HUNT, FILL, DROP} wr_state_t;
  wr_state_t state, state_n;
  logic [7:0] mem [DEPTH*256];
  logic [SLOT_BITS-1:0] wr_slot, rd_slot;
  logic [SLOT_BITS:0] fill;
  logic [7:0] wr_idx, wr_idx_n, widx, rd_idx, cur_idx, null_byte, mem_q, null_q;
  logic start, full, go, we, commit, drop_trunc, drop_full;
  logic rd_active, rd_null, claim, is_null, last;
  logic out_valid, out_syn, out_null, sel_null;
  // The slot being streamed out is no longer in fill but must not be overwritten,
  // so it still counts against capacity until the reader finishes it.
  assign full = ({1'b0, fill} + {{(SLOT_BITS + 1){1'b0}}, rd_active & ~rd_null}) >= FULL;
  always_comb begin
    start = bus.in_valid & bus.in_syn & (bus.in_data == 8'h47);
    go = (state == HUNT) | (bus.in_valid & bus.in_syn);
    drop_trunc = (state == FILL) & bus.in_valid & bus.in_syn;
    state_n = state;
    we = 1'b0;
    widx = wr_idx;
    wr_idx_n = wr_idx;
    commit = 1'b0;
    drop_full = 1'b0;
    if (go) begin
      state_n = start ? (full ? DROP : FILL) : HUNT;
      we = start & ~full;
      widx = 8'd0;
      wr_idx_n = 8'd1;
      drop_full = start & full;
    end else if (state == FILL && bus.in_valid) begin
      we = 1'b1;
      commit = wr_idx == LAST;
      state_n = commit ? HUNT : FILL;
      wr_idx_n = wr_idx + 8'd1;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= HUNT;
      wr_idx <= 8'd0;
    end else begin
      state <= state_n;
      wr_idx <= wr_idx_n;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (we) mem[{wr_slot, widx}] <= bus.in_data;
    mem_q <= mem[{rd_slot, cur_idx}];
  end
  // A commit in the same cycle makes its slot claimable immediately.
  always_comb begin
    cur_idx = rd_active ? rd_idx : 8'd0;
    claim = bus.out_req & ~rd_active & ((fill != '0) | commit);
    is_null = rd_active ? rd_null : ~claim;
    last = cur_idx == LAST;
    null_byte = cur_idx == 8'd0 ? 8'h47 : cur_idx == 8'd1 ? 8'h1F : cur_idx == 8'd3 ? 8'h10 : 8'hFF;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_slot <= '0;
      rd_slot <= '0;
      fill <= '0;
      rd_active <= 1'b0;
      rd_null <= 1'b0;
      rd_idx <= 8'd0;
      out_valid <= 1'b0;
      out_syn <= 1'b0;
      out_null <= 1'b0;
      sel_null <= 1'b0;
      null_q <= 8'd0;
      pkt_in_cnt <= 32'd0;
      null_cnt <= 32'd0;
      drop_cnt <= 32'd0;
    end else begin
      out_valid <= bus.out_req;
      out_syn <= bus.out_req & (cur_idx == 8'd0);
      out_null <= bus.out_req & is_null;
      sel_null <= is_null;
      null_q <= null_byte;
      fill <= fill + {{SLOT_BITS{1'b0}}, commit} - {{SLOT_BITS{1'b0}}, claim};
      drop_cnt <= drop_cnt + 32'(drop_trunc) + 32'(drop_full);
      if (commit) begin
        wr_slot <= wr_slot + 1'b1;
        pkt_in_cnt <= pkt_in_cnt + 32'd1;
      end
      if (bus.out_req) begin
        rd_active <= ~last;
        rd_null <= is_null;
        rd_idx <= cur_idx + 8'd1;
        if (~rd_active & is_null) null_cnt <= null_cnt + 32'd1;
        if (last & ~is_null) rd_slot <= rd_slot + 1'b1;
      end
    end
  end
  assign bus.out_valid = out_valid;
  assign bus.out_syn = out_syn;
  assign bus.out_null = out_null;
  assign bus.out_data = ~out_valid ? 8'h00 : sel_null ? null_q : mem_q;
endmodule

// File: tb/tb_dvb_s2_ts_null_inserter.sv
// tb_dvb_s2_ts_null_inserter: scoreboard bench for the TS null-packet inserter
module tb_dvb_s2_ts_null_inserter;
  logic sys_clk, rst;
  logic [31:0] pkt_in_cnt, null_cnt, drop_cnt;
  logic [9:0] q[$];
  int vec, err;
  dvb_s2_ts_null_inserter_if bus();
  dvb_s2_ts_null_inserter dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus),
    .pkt_in_cnt(pkt_in_cnt),
    .null_cnt(null_cnt),
    .drop_cnt(drop_cnt)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  function automatic logic [7:0] pb(int seed, int i);
    return i == 0 ? 8'h47 : 8'(seed + i - 1);
  endfunction
  function automatic logic [7:0] nb(int i);
    return i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 2 ? 8'hFF : i == 3 ? 8'h10 : 8'hFF;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic exp_real(int seed);
    for (int i = 0; i < 188; i++) q.push_back({pb(seed, i), i == 0, 1'b0});
  endtask
  task automatic exp_null(int n);
    for (int i = 0; i < n; i++) q.push_back({nb(i), i == 0, 1'b1});
  endtask
  task automatic send(int seed, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_syn = i == 0;
      bus.in_data = pb(seed, i);
    end
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_syn = 1'b0;
  endtask
  task automatic raw(logic [7:0] d, logic s);
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_syn = s;
    bus.in_data = d;
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_syn = 1'b0;
  endtask
  task automatic req(int n, int gap);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
      bus.out_req = 1'b1;
      for (int g = 0; g < gap; g++) begin
        @(posedge sys_clk);
        #1;
        bus.out_req = 1'b0;
      end
    end
    @(posedge sys_clk);
    #1;
    bus.out_req = 1'b0;
  endtask
  task automatic drain(string nm);
    repeat (3) @(negedge sys_clk);
    chk(nm, q.size(), 0);
  endtask
  initial begin
    vec = 0;
    err = 0;
    rst = 1'b1;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_syn = 1'b0;
    bus.out_req = 1'b0;
    fork
      forever begin
        @(negedge sys_clk);
        if (!rst && bus.out_valid) begin
          vec++;
          if (q.size() == 0) begin
            err++;
            $display("FAIL unexpected_byte: got %0h with nothing expected", bus.out_data);
          end else begin
            logic [9:0] e;
            e = q.pop_front();
            if ({bus.out_data, bus.out_syn, bus.out_null} !== e) begin
              err++;
              $display("FAIL out_byte: got data=%0h syn=%0b null=%0b expected data=%0h syn=%0b null=%0b",
                       bus.out_data, bus.out_syn, bus.out_null, e[9:2], e[1], e[0]);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", 32'(bus.out_valid), 0);
    chk("reset_data", 32'(bus.out_data), 0);
    chk("reset_cnts", pkt_in_cnt | null_cnt | drop_cnt, 0);
    exp_null(188);
    exp_null(188);
    req(376, 0);
    drain("t1_drain");
    chk("t1_null_cnt", null_cnt, 2);
    send(0, 188);
    chk("t2_pkt_in", pkt_in_cnt, 1);
    exp_real(0);
    req(188, 1);
    drain("t2_drain");
    for (int p = 0; p < 5; p++) send(10 * (p + 1), 188);
    chk("t3_pkt_in", pkt_in_cnt, 5);
    chk("t3_drop", drop_cnt, 1);
    for (int p = 0; p < 4; p++) exp_real(10 * (p + 1));
    exp_null(188);
    req(5 * 188, 0);
    drain("t3_drain");
    chk("t3_null_cnt", null_cnt, 3);
    raw(8'h12, 1'b1);
    raw(8'h33, 1'b0);
    send(60, 100);
    send(70, 188);
    chk("t4_drop", drop_cnt, 2);
    chk("t4_pkt_in", pkt_in_cnt, 6);
    exp_real(70);
    req(188, 0);
    drain("t4_drain");
    chk("t4_null_cnt", null_cnt, 3);
    exp_null(188);
    exp_real(80);
    fork
      send(80, 188);
      begin
        repeat (10) @(posedge sys_clk);
        req(376, 0);
      end
    join
    drain("t5_drain");
    chk("t5_pkt_in", pkt_in_cnt, 7);
    chk("t5_null_cnt", null_cnt, 4);
    exp_null(50);
    fork
      send(90, 50);
      req(50, 0);
    join
    @(posedge sys_clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h05;
    bus.out_req = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_syn_null", 32'({bus.out_syn, bus.out_null}), 0);
    chk("t6_data", 32'(bus.out_data), 0);
    chk("t6_cnts", pkt_in_cnt | null_cnt | drop_cnt, 0);
    chk("t6_queue", q.size(), 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_req = 1'b0;
    exp_null(188);
    req(188, 0);
    drain("t6_drain");
    chk("t6_null_cnt", null_cnt, 1);
    chk("t6_pkt_in", pkt_in_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
